multicycle_control_unit: RTL

FSM-based control unit for the multicycle MIPS datapath. It uses the same cpu_types_pkg opcode/funct encodings and the same mux-select meanings as the single-cycle control decode. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, stalls on instruction/data memory hits, and adds an LL/SC link-reservation tracker, memory-wait timeout detection, and sticky halt/error states.

---
 rtl/multicycle_control_unit.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Purpose  : FSM control unit for the multicycle MIPS datapath. Sequences each
//            instruction through FETCH/DECODE/EXEC/MEM/WB, stalls on memory
//            hits, tracks the LL/SC link reservation, detects memory-wait
//            timeouts and holds sticky HALTED/ERROR states.
// Ports    : CLK, nRST (sync active-low) | instr, ihit, dhit, zero, dmemaddr,
//            snoop_valid, snoop_addr in | memory / IR / PC / regfile enables,
//            datapath selects, aluOp, sc_result, halt, timeout, state out.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
  parameter int LINK_EN  = 1,
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] instr,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        zero,
  input  logic [31:0] dmemaddr,
  input  logic        snoop_valid,
  input  logic [31:0] snoop_addr,
  output logic        imemREN,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic        ir_wen,
  output logic        pc_wen,
  output logic        regWEN,
  output logic [3:0]  aluOp,
  output logic [2:0]  pc_sel,
  output logic [1:0]  portb_sel,
  output logic        porta_sel,
  output logic        immExt_sel,
  output logic [1:0]  regW_sel,
  output logic [1:0]  wMemReg_sel,
  output logic        sc_result,
  output logic        halt,
  output logic        timeout,
  output logic [2:0]  state
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI  = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI  = 6'h0E,
                         OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW    = 6'h2B,
                         OP_LL    = 6'h30, OP_SC   = 6'h38, OP_HALT  = 6'h3F;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SLLV = 6'h04,
                         F_SRLV = 6'h06, F_JR   = 6'h08, F_ADD  = 6'h20,
                         F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23,
                         F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26,
                         F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2,
                         ALU_SUB = 4'd3, ALU_AND = 4'd4, ALU_OR  = 4'd5,
                         ALU_XOR = 4'd6, ALU_NOR = 4'd7, ALU_SLT = 4'd8,
                         ALU_SLTU = 4'd9;

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
    S_WB    = 3'd4, S_HALTED = 3'd5, S_ERROR = 3'd6
  } state_t;

  state_t              state_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                sc_result_q, halt_q, timeout_q;
  logic                link_valid_q;
  logic [31:0]         link_addr_q;

  logic [5:0] w_op, w_funct;
  logic       w_is_lw, w_is_sw, w_is_ll, w_is_sc, w_is_jr, w_is_mem;
  logic       w_known_op, w_dest_zero, w_sc_ok, w_mem_access, w_wait_expired;
  logic       w_unused;

  assign w_op           = instr[31:26];
  assign w_funct        = instr[5:0];
  assign w_is_lw        = (w_op == OP_LW);
  assign w_is_sw        = (w_op == OP_SW);
  assign w_is_ll        = (w_op == OP_LL);
  assign w_is_sc        = (w_op == OP_SC);
  assign w_is_jr        = (w_op == OP_RTYPE) && (w_funct == F_JR);
  assign w_is_mem       = w_is_lw | w_is_sw | w_is_ll | w_is_sc;
  assign w_dest_zero    = (w_op == OP_RTYPE) ? (instr[15:11] == 5'd0) : (instr[20:16] == 5'd0);
  assign w_sc_ok        = (LINK_EN == 0) || (link_valid_q && (link_addr_q == dmemaddr));
  // A failed SC performs no memory access at all, so it never waits on dhit.
  assign w_mem_access   = w_is_lw | w_is_ll | w_is_sw | (w_is_sc & w_sc_ok);
  assign w_wait_expired = (wait_cnt_q == WAIT_MAX);
  assign w_unused       = ^{instr[25:21], instr[10:6]};

  always_comb begin
    case (w_op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW, OP_LL,
      OP_SC, OP_HALT: w_known_op = 1'b1;
      default:        w_known_op = 1'b0;
    endcase
  end

  // Datapath selects decode from instr in every state.
  always_comb begin
    aluOp       = ALU_ADD;
    portb_sel   = 2'b10;
    porta_sel   = 1'b0;
    immExt_sel  = 1'b1;
    regW_sel    = 2'b01;
    wMemReg_sel = 2'b00;
    case (w_op)
      OP_RTYPE: begin
        portb_sel = 2'b00;
        regW_sel  = 2'b00;
        case (w_funct)
          F_SLL:         begin aluOp = ALU_SLL; portb_sel = 2'b01; end
          F_SRL:         begin aluOp = ALU_SRL; portb_sel = 2'b01; end
          F_SLLV:        aluOp = ALU_SLL;
          F_SRLV:        aluOp = ALU_SRL;
          F_ADD, F_ADDU: aluOp = ALU_ADD;
          F_SUB, F_SUBU: aluOp = ALU_SUB;
          F_AND:         aluOp = ALU_AND;
          F_OR:          aluOp = ALU_OR;
          F_XOR:         aluOp = ALU_XOR;
          F_NOR:         aluOp = ALU_NOR;
          F_SLT:         aluOp = ALU_SLT;
          F_SLTU:        aluOp = ALU_SLTU;
          default:       aluOp = ALU_ADD;
        endcase
      end
      OP_JAL:          begin regW_sel = 2'b10; wMemReg_sel = 2'b10; end
      OP_BEQ, OP_BNE:  begin aluOp = ALU_SUB; portb_sel = 2'b00; end
      OP_SLTI:         aluOp = ALU_SLT;
      OP_SLTIU:        aluOp = ALU_SLTU;
      OP_ANDI:         begin aluOp = ALU_AND; immExt_sel = 1'b0; end
      OP_ORI:          begin aluOp = ALU_OR;  immExt_sel = 1'b0; end
      OP_XORI:         begin aluOp = ALU_XOR; immExt_sel = 1'b0; end
      // LUI: zero-extended immediate on port A shifted left by 16 on port B.
      OP_LUI:          begin aluOp = ALU_SLL; porta_sel = 1'b1; portb_sel = 2'b11; immExt_sel = 1'b0; end
      OP_LW, OP_LL:    wMemReg_sel = 2'b01;
      OP_SC:           wMemReg_sel = 2'b11;
      default:         ;
    endcase
  end

  // Enables; all forced low while reset is asserted so an abandoned access
  // never writes in the reset cycle.
  always_comb begin
    imemREN = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    ir_wen  = 1'b0;
    pc_wen  = 1'b0;
    regWEN  = 1'b0;
    pc_sel  = 3'b000;
    if (nRST) begin
      case (state_q)
        S_FETCH: begin
          imemREN = 1'b1;
          ir_wen  = ihit;
          pc_wen  = ihit;
        end
        S_DECODE: begin
          if (w_op == OP_J || w_op == OP_JAL) begin
            pc_wen = 1'b1;
            pc_sel = 3'b010;
            regWEN = (w_op == OP_JAL);
          end
        end
        S_EXEC: begin
          if (w_is_jr) begin
            pc_wen = 1'b1;
            pc_sel = 3'b001;
          end else if (w_op == OP_BEQ || w_op == OP_BNE) begin
            pc_sel = 3'b011;
            pc_wen = ((w_op == OP_BEQ) & zero) | ((w_op == OP_BNE) & ~zero);
          end
        end
        S_MEM: begin
          dmemREN = w_is_lw | w_is_ll;
          dmemWEN = w_is_sw | (w_is_sc & w_sc_ok);
        end
        S_WB:    regWEN = ~w_dest_zero & ~w_is_sw;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= S_FETCH;
      wait_cnt_q  <= '0;
      sc_result_q <= 1'b0;
      halt_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (ihit) begin
            state_q    <= S_DECODE;
            wait_cnt_q <= '0;
          end else if (w_wait_expired) begin
            state_q    <= S_ERROR;
            wait_cnt_q <= '0;
            halt_q     <= 1'b1;
            timeout_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          if (w_op == OP_HALT) begin
            state_q <= S_HALTED;
            halt_q  <= 1'b1;
          end else if (w_op == OP_J || w_op == OP_JAL || !w_known_op) begin
            state_q <= S_FETCH;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_jr || w_op == OP_BEQ || w_op == OP_BNE) state_q <= S_FETCH;
          else if (w_is_mem)                               state_q <= S_MEM;
          else                                             state_q <= S_WB;
        end
        S_MEM: begin
          if (!w_mem_access) begin
            sc_result_q <= 1'b0;
            state_q     <= S_WB;
            wait_cnt_q  <= '0;
          end else if (dhit) begin
            if (w_is_sc) sc_result_q <= 1'b1;
            // A store has nothing to write back, so it returns straight to fetch.
            state_q    <= w_is_sw ? S_FETCH : S_WB;
            wait_cnt_q <= '0;
          end else if (w_wait_expired) begin
            state_q    <= S_ERROR;
            wait_cnt_q <= '0;
            halt_q     <= 1'b1;
            timeout_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        S_WB:     state_q <= S_FETCH;
        S_HALTED: state_q <= S_HALTED;
        S_ERROR:  state_q <= S_ERROR;
        default:  state_q <= S_ERROR;
      endcase
    end
  end

  generate
    if (LINK_EN != 0) begin : g_link
      logic w_in_mem, w_ll_set, w_sw_clr, w_sc_clr, w_snoop_clr;
      assign w_in_mem = (state_q == S_MEM);
      assign w_ll_set = w_in_mem & w_is_ll & dhit;
      assign w_sw_clr = w_in_mem & w_is_sw & dhit & (dmemaddr == link_addr_q);
      assign w_sc_clr = w_in_mem & w_is_sc & (~w_sc_ok | dhit);
      // A snoop also kills a reservation being created at the same address
      // in the same cycle.
      assign w_snoop_clr = snoop_valid & ((snoop_addr == link_addr_q) |
                                          (w_ll_set & (snoop_addr == dmemaddr)));
      always_ff @(posedge CLK) begin
        if (!nRST) begin
          link_valid_q <= 1'b0;
          link_addr_q  <= '0;
        end else if (w_snoop_clr || w_sc_clr || w_sw_clr) begin
          link_valid_q <= 1'b0;
        end else if (w_ll_set) begin
          link_valid_q <= 1'b1;
          link_addr_q  <= dmemaddr;
        end
      end
    end else begin : g_no_link
      assign link_valid_q = 1'b0;
      assign link_addr_q  = '0;
    end
  endgenerate

  assign sc_result = sc_result_q;
  assign halt      = halt_q;
  assign timeout   = timeout_q;
  assign state     = state_q;

endmodule
`default_nettype wire
